digitron_scan_scheduler: RTL and testbench
==========================================

Name: digitron_scan_scheduler

Overview:
- Owns the shared 8-digit 7-segment display (active-low `seq`/`an`) and an 8-entry glyph frame buffer.
- Several glyph producers (hello/fin/digit text generators) write glyphs into the buffer through a round-robin req/gnt port.
- The block time-multiplexes the buffer onto the display: one digit slot per SCAN_DIV clocks, with an anti-ghosting blank interval at the end of each slot.
- Replaces per-producer direct drive of `seq`/`an`.

Parameters:
- NUM_REQ, 3: number of write requesters (1..8).
- SCAN_DIV, 16384: clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 4: blanked cycles at the end of each slot (1..SCAN_DIV-1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  write request per requester; held until granted.
- wr_digit  in  3*NUM_REQ  target digit index 0..7; requester i uses bits [3i+2:3i].
- wr_glyph  in  8*NUM_REQ  active-low segment pattern {a..g,dp}; requester i uses bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot, combinational; the write happens at the clock edge where gnt[i]=1.
- clear  in  1  synchronous buffer clear.
- seq  out  8  registered segment drive, active-low.
- an  out  8  registered anode drive, active-low, at most one bit low.
- frame_done  out  1  registered one-cycle pulse per completed 8-digit frame.

Behaviour:
- Reset (asynchronous, active-high):
  - buffer[0..7]=8'hFF, seq=8'hFF, an=8'hFF, frame_done=0.
  - idx=0, div_cnt=0, rr_ptr=0.
  - A reset mid-slot or mid-write discards everything; no write occurs while reset is high.
- Arbitration (combinational):
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - gnt = onehot(winner); gnt=0 if req==0 or clear==1.
- Write (each posedge):
  - If clear: all buffer entries <= 8'hFF. Clear beats any write; no grant is issued that cycle.
  - Else if a grant is active: buffer[wr_digit of winner] <= wr_glyph of winner; rr_ptr <= (winner+1) mod NUM_REQ.
  - With no request, rr_ptr holds.
  - Only one write per cycle; losers hold req.
- Scan counter:
  - div_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and idx <= idx+1, wrapping 7->0.
- Scan phase, decoded from pre-edge div_cnt:
  - SHOW when div_cnt < SCAN_DIV-BLANK_CYCLES, else BLANK.
- Output registers (each posedge, from pre-edge idx, div_cnt and buffer):
  - SHOW: an <= ~(8'b1<<idx), seq <= buffer[idx].
  - BLANK: an <= 8'hFF, seq <= 8'hFF.
- Write-to-display latency:
  - A write at edge N to the digit being shown appears on seq at edge N+1.
  - If the write lands in a blank phase, it appears at the next SHOW of that digit.
- Timing after reset release, in edges k=1,2,...:
  - Digit 0 is shown for edges 1..S-B.
  - Blank for edges S-B+1..S.
  - Digit 1 is shown from edge S+1, and so on (S=SCAN_DIV, B=BLANK_CYCLES).
- frame_done <= 1 on the edge where idx=7 and div_cnt=SCAN_DIV-1, otherwise 0.
- Scan runs continuously; clear and writes never stall it.
- Invariant: an never has more than one low bit. A digit change is always separated by at least BLANK_CYCLES cycles of an=8'hFF.

Decomposition:
- Package digitron_pkg:
  - GLYPH_BLANK=8'hFF, AN_OFF=8'hFF.
  - Digit glyph constants 0–9, with DP-on mask 8'hFE.
  - Letter glyphs H, E, L, O, F, I, N.
  - Function an_decode(idx) returning ~(1<<idx).
  - Typedefs glyph_t (8 bits) and digit_idx_t (3 bits).
- One sub-module: rr_arbiter (NUM_REQ parameter).
  - Inputs: req, mask/clear, advance.
  - Outputs: one-hot gnt and winner index.
  - Holds rr_ptr internally.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2 unless noted):
- Reset then idle: seq=FF, an=FF during reset. Then an = FE for edges 1–6, FF for edges 7–8, FD from edge 9. seq=FF throughout. frame_done high only after edge 64, and every 64 cycles after that.
- Single write: req[0]=1, wr_digit0=2, wr_glyph0=8'h03. Expect gnt=001 that cycle. seq=8'h03 whenever an=FB, otherwise FF.
- Contention: req=111 held continuously from reset. Grants go 001, 010, 100, 001 on consecutive cycles; each requester's glyph lands in its own target digit.
- Clear collision: req[1]=1 and clear=1 in the same cycle. gnt=000 and all digits FF. On the next cycle (clear=0), gnt=010 and the write lands.
- Async reset mid-slot (reset high at div_cnt=3 of idx 5): outputs go FF/FF immediately and the buffer clears. After release, scanning restarts at idx 0 with an=FE.
- Ghosting check (any params; run random writes for 10 frames): an is never two-low, and every change of the low bit passes through BLANK_CYCLES cycles of FF.

Source files
------------

// File: rtl/digitron_pkg.sv
// digitron_pkg: shared glyph constants, types and anode decode for the 8-digit display
package digitron_pkg;
  typedef logic [7:0] glyph_t;
  typedef logic [2:0] digit_idx_t;
  localparam glyph_t GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam glyph_t DP_ON_MASK = 8'hFE;
  localparam glyph_t GLYPH_0 = 8'h03;
  localparam glyph_t GLYPH_1 = 8'h9F;
  localparam glyph_t GLYPH_2 = 8'h25;
  localparam glyph_t GLYPH_3 = 8'h0D;
  localparam glyph_t GLYPH_4 = 8'h99;
  localparam glyph_t GLYPH_5 = 8'h49;
  localparam glyph_t GLYPH_6 = 8'h41;
  localparam glyph_t GLYPH_7 = 8'h1F;
  localparam glyph_t GLYPH_8 = 8'h01;
  localparam glyph_t GLYPH_9 = 8'h09;
  localparam glyph_t GLYPH_H = 8'h91;
  localparam glyph_t GLYPH_E = 8'h61;
  localparam glyph_t GLYPH_L = 8'hE3;
  localparam glyph_t GLYPH_O = 8'h03;
  localparam glyph_t GLYPH_F = 8'h71;
  localparam glyph_t GLYPH_I = 8'hF3;
  localparam glyph_t GLYPH_N = 8'hD5;

  function automatic logic [7:0] an_decode(input digit_idx_t idx);
    return ~(8'b1 << idx);
  endfunction

  function automatic glyph_t digit_glyph(input logic [3:0] d);
    return d == 4'd0 ? GLYPH_0 :
           d == 4'd1 ? GLYPH_1 :
           d == 4'd2 ? GLYPH_2 :
           d == 4'd3 ? GLYPH_3 :
           d == 4'd4 ? GLYPH_4 :
           d == 4'd5 ? GLYPH_5 :
           d == 4'd6 ? GLYPH_6 :
           d == 4'd7 ? GLYPH_7 :
           d == 4'd8 ? GLYPH_8 :
           d == 4'd9 ? GLYPH_9 : GLYPH_BLANK;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a masking clear and pointer advance on grant
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                clear,
  input  logic                advance,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [(NUM_REQ>1 ? $clog2(NUM_REQ) : 1)-1:0] win
);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic found;
  int c;
  // first requester at or after the pointer, wrapping; clear suppresses the grant
  always_comb begin
    found = 1'b0;
    win = '0;
    c = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req[c]) begin
        found = 1'b1;
        win = RW'(c);
      end
    end
    gnt = (found && !clear) ? (NUM_REQ'(1) << win) : '0;
    rr_ptr_d = (found && !clear && advance) ? (win == RW'(NUM_REQ-1) ? '0 : win + RW'(1)) : rr_ptr_q;
  end
  // pointer moves past the winner only when a grant is taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/digitron_scan_scheduler.sv
// digitron_scan_scheduler: glyph frame buffer with arbitrated writes, multiplexed onto an 8-digit display
module digitron_scan_scheduler
  import digitron_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SCAN_DIV = 16384,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [3*NUM_REQ-1:0]  wr_digit,
  input  logic [8*NUM_REQ-1:0]  wr_glyph,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  clear,
  output logic [7:0]            seq,
  output logic [7:0]            an,
  output logic                  frame_done
);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  logic [RW-1:0] win;
  glyph_t buffer_q [8];
  glyph_t buffer_d [8];
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t idx_q, idx_d;
  glyph_t seq_q, seq_d;
  logic [7:0] an_q, an_d;
  logic frame_done_q, frame_done_d;
  logic slot_end, show;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .clear   (clear),
    .advance (1'b1),
    .gnt     (gnt),
    .win     (win)
  );

  // buffer update: clear wins over the granted write
  always_comb begin
    buffer_d = buffer_q;
    if (clear) for (int i = 0; i < 8; i++) buffer_d[i] = GLYPH_BLANK;
    else if (|gnt) buffer_d[wr_digit[3*int'(win) +: 3]] = wr_glyph[8*int'(win) +: 8];
  end

  // slot counter, digit index and the registered display drive for the next cycle
  always_comb begin
    slot_end = div_cnt_q == DW'(SCAN_DIV-1);
    show = div_cnt_q < DW'(SCAN_DIV-BLANK_CYCLES);
    div_cnt_d = slot_end ? '0 : div_cnt_q + DW'(1);
    idx_d = slot_end ? idx_q + 3'd1 : idx_q;
    an_d = show ? an_decode(idx_q) : AN_OFF;
    seq_d = show ? buffer_q[idx_q] : GLYPH_BLANK;
    frame_done_d = slot_end && idx_q == 3'd7;
  end

  // all state restarts from a blank display at digit 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) buffer_q[i] <= GLYPH_BLANK;
      div_cnt_q <= '0;
      idx_q <= '0;
      seq_q <= GLYPH_BLANK;
      an_q <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      buffer_q <= buffer_d;
      div_cnt_q <= div_cnt_d;
      idx_q <= idx_d;
      seq_q <= seq_d;
      an_q <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seq = seq_q;
  assign an = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_digitron_scan_scheduler.sv
// tb_digitron_scan_scheduler: directed and random stimulus against a cycle model with an output scoreboard
module tb_digitron_scan_scheduler;
  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seq;
    logic fd;
  } exp_t;

  logic clock, reset, clear;
  logic [2:0] req;
  logic [8:0] wr_digit;
  logic [23:0] wr_glyph;
  logic [2:0] gnt;
  logic [7:0] seq, an;
  logic frame_done;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  logic [7:0] m_buf [8];
  int m_idx, m_div, m_rr;
  int prev_low, ff_run, fd_count;
  logic [2:0] last_gnt;
  logic [2:0] gseq [4];

  digitron_scan_scheduler #(.NUM_REQ(3), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .wr_digit   (wr_digit),
    .wr_glyph   (wr_glyph),
    .gnt        (gnt),
    .clear      (clear),
    .seq        (seq),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_seq", seq, 8'hFF);
    check("rst_fd", {7'b0, frame_done}, 8'h00);
    for (int i = 0; i < 8; i++) m_buf[i] = 8'hFF;
    m_idx = 0;
    m_div = 0;
    m_rr = 0;
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    prev_low = -1;
    ff_run = 0;
    fd_count = 0;
  endtask

  task automatic step();
    logic [2:0] eg;
    int w;
    int low;
    logic show;
    exp_t e, o;
    #1;
    eg = '0;
    w = -1;
    if (!clear) for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_rr + k) % 3;
      if (w < 0 && req[c]) w = c;
    end
    if (w >= 0) eg = 3'b1 << w;
    check("gnt", {5'b0, gnt}, {5'b0, eg});
    last_gnt = gnt;
    show = m_div < 6;
    e.an = show ? ~(8'b1 << m_idx) : 8'hFF;
    e.seq = show ? m_buf[m_idx] : 8'hFF;
    e.fd = (m_idx == 7 && m_div == 7);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (clear) for (int i = 0; i < 8; i++) m_buf[i] = 8'hFF;
    else if (w >= 0) begin
      m_buf[wr_digit[3*w +: 3]] = wr_glyph[8*w +: 8];
      m_rr = (w + 1) % 3;
    end
    if (m_div == 7) begin
      m_div = 0;
      m_idx = (m_idx + 1) % 8;
    end else m_div++;
    o = sb.pop_front();
    check("an", an, o.an);
    check("seq", seq, o.seq);
    check("frame_done", {7'b0, frame_done}, {7'b0, o.fd});
    if (frame_done) fd_count++;
    check("an_onehot0", {7'b0, $countones(~an) <= 1}, 8'd1);
    if (an == 8'hFF) ff_run++;
    else begin
      low = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) low = i;
      if (prev_low >= 0 && low != prev_low) check("blank_gap", ff_run >= 2 ? 8'd1 : 8'd0, 8'd1);
      prev_low = low;
      ff_run = 0;
    end
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    clear = 1'b0;
    req = '0;
    wr_digit = '0;
    wr_glyph = '0;
    gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
    #2;
    do_reset();
    for (int n = 0; n < 70; n++) step();
    check("fd_pulses", 8'(fd_count), 8'd1);
    req = 3'b001;
    wr_digit = 9'd2;
    wr_glyph = 24'h000003;
    step();
    check("single_gnt", {5'b0, last_gnt}, 8'h01);
    req = '0;
    for (int n = 0; n < 20; n++) step();
    req = 3'b010;
    wr_digit = 9'd5 << 3;
    wr_glyph = 24'h49 << 8;
    clear = 1'b1;
    step();
    check("clear_gnt", {5'b0, last_gnt}, 8'h00);
    clear = 1'b0;
    step();
    check("after_clear_gnt", {5'b0, last_gnt}, 8'h02);
    req = '0;
    for (int n = 0; n < 64; n++) step();
    req = 3'b111;
    wr_digit = {3'd6, 3'd3, 3'd1};
    wr_glyph = {8'h99, 8'h0D, 8'h9F};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("contention_gnt", {5'b0, last_gnt}, {5'b0, gseq[i]});
    end
    req = '0;
    for (int n = 0; n < 70; n++) step();
    for (int n = 0; n < 200 && !(m_idx == 5 && m_div == 3); n++) step();
    check("reach_idx5", 8'(m_idx), 8'd5);
    do_reset();
    step();
    check("restart_an", an, 8'hFE);
    for (int n = 0; n < 640; n++) begin
      req = 3'($urandom_range(0, 7));
      wr_digit = 9'($urandom);
      wr_glyph = 24'($urandom);
      clear = $urandom_range(0, 19) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
